// File: rtl/ram_unit_pkg.sv
// Shared definitions for the SAP RAM responder: default widths and the
// clear-sequencer FSM state encoding.
package ram_unit_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 10;

    // IDLE serves CPU strobes and the loader; CLEAR zeroes the whole array.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage

// File: rtl/ram_unit_array.sv
// Program/data storage: DEPTH x DATA_W, one synchronous write port and one
// synchronous read port. Reads return the contents before a same-edge write.
module ram_array #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 10
) (
    input  logic              CLK,
    input  logic              ARST_L,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_W;

    // Storage is intentionally not reset; contents survive ARST_L.
    logic [DATA_W-1:0] mem [DEPTH];

    // Single write port, already arbitrated by the owner.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read of the addressed word every cycle; only the output
    // register is reset so the bus sees 0 out of reset.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/ram_unit.sv
// SAP RAM bus responder: executes CPU MAR-load / read / write strobes,
// accepts words from the halted-mode loader and runs the whole-memory clear.
//
// Loader handshake: a word transfers on a CLK edge where ld_valid and ld_ready
// are both high. ld_ready depends only on state, ld_en, clr_req and the CPU
// write in the same cycle, never on ld_valid, so the source may hold ld_valid
// while waiting. At most one word is accepted per CLK.
module ram_unit
    import ram_unit_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              ARST_L,
    input  logic              SLOW_CLOCK_STRB,
    input  logic              mar_in,
    input  logic              ram_out,
    input  logic              ram_wr,
    input  logic [DATA_W-1:0] bus_in,
    output logic [DATA_W-1:0] bus_out,
    output logic              bus_oe,
    input  logic              ld_en,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              clr_req,
    output logic              busy,
    output logic [ADDR_W:0]   ld_count,
    output logic              err_conflict,
    output logic              err_busy,
    output logic              state_dbg
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LD_MAX = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] mar;
    logic [ADDR_W-1:0] clr_cnt;
    logic              clr_last;
    logic              clr_we;
    logic              is_idle;
    logic              cpu_any;
    logic              cpu_wr;
    logic              cpu_conflict;
    logic              ld_fire;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_wa;
    logic [DATA_W-1:0] mem_wd;
    logic [DATA_W-1:0] rd_data;

    assign is_idle      = (state == ST_IDLE);
    assign cpu_any      = SLOW_CLOCK_STRB && (mar_in || ram_wr || ram_out);
    assign cpu_wr       = is_idle && SLOW_CLOCK_STRB && ram_wr && !ram_out;
    assign cpu_conflict = is_idle && SLOW_CLOCK_STRB && ram_wr && ram_out;
    assign clr_last     = (clr_cnt == '1);
    assign ld_fire      = ld_valid && ld_ready;
    assign state_dbg    = state;

    // FSM state register.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: a clear runs for exactly DEPTH cycles and ignores clr_req.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (clr_req)  state_nxt = ST_CLEAR;
            ST_CLEAR: if (clr_last) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: clear ownership of the write port, busy, loader readiness.
    always_comb begin
        busy     = 1'b0;
        clr_we   = 1'b0;
        ld_ready = 1'b0;
        case (state)
            ST_IDLE:  ld_ready = ld_en && !clr_req && !cpu_wr;
            ST_CLEAR: begin
                busy   = 1'b1;
                clr_we = 1'b1;
            end
            default:  ld_ready = 1'b0;
        endcase
    end

    // Clear address counter: held at 0 while idle so every clear starts at 0.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            clr_cnt <= '0;
        end else if (is_idle) begin
            clr_cnt <= '0;
        end else begin
            clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // MAR loads only on an idle strobe; strobes during a clear are dropped.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            mar <= '0;
        end else if (is_idle && SLOW_CLOCK_STRB && mar_in) begin
            mar <= bus_in[ADDR_W-1:0];
        end
    end

    // Write-port arbitration: clear, then CPU write (old MAR), then loader.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = mar;
        mem_wd = bus_in;
        if (clr_we) begin
            mem_we = 1'b1;
            mem_wa = clr_cnt;
            mem_wd = '0;
        end else if (cpu_wr) begin
            mem_we = 1'b1;
            mem_wa = mar;
            mem_wd = bus_in;
        end else if (ld_fire) begin
            mem_we = 1'b1;
            mem_wa = ld_addr;
            mem_wd = ld_data;
        end
    end

    // Loader word counter: saturates at DEPTH, zeroed when a clear completes.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            ld_count <= '0;
        end else if (clr_we && clr_last) begin
            ld_count <= '0;
        end else if (ld_fire && (ld_count != LD_MAX)) begin
            ld_count <= ld_count + 1'b1;
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLK or negedge ARST_L) begin
        if (!ARST_L) begin
            err_conflict <= 1'b0;
            err_busy     <= 1'b0;
        end else begin
            if (cpu_conflict) err_conflict <= 1'b1;
            if (!is_idle && cpu_any) err_busy <= 1'b1;
        end
    end

    ram_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram_array (
        .CLK     (CLK),
        .ARST_L  (ARST_L),
        .we      (mem_we),
        .wr_addr (mem_wa),
        .wr_data (mem_wd),
        .rd_addr (mar),
        .rd_data (rd_data)
    );

    // Bus drive follows ram_out combinationally but is blocked during a clear.
    always_comb begin
        bus_oe  = ram_out && !busy;
        bus_out = bus_oe ? rd_data : '0;
    end

endmodule

// File: tb/tb_ram_unit.sv
// Bench for ram_unit: random and directed CPU/loader/clear traffic against an
// array-based model; reads are checked by a monitor draining an expected queue.
module tb_ram_unit;

    localparam int AW    = 8;
    localparam int DW    = 10;
    localparam int DEPTH = 256;

    logic          CLK = 1'b0;
    logic          ARST_L = 1'b0;
    logic          SLOW_CLOCK_STRB = 1'b0;
    logic          mar_in = 1'b0;
    logic          ram_out = 1'b0;
    logic          ram_wr = 1'b0;
    logic [DW-1:0] bus_in = '0;
    logic [DW-1:0] bus_out;
    logic          bus_oe;
    logic          ld_en = 1'b0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_data = '0;
    logic          clr_req = 1'b0;
    logic          busy;
    logic [AW:0]   ld_count;
    logic          err_conflict;
    logic          err_busy;
    logic          state_dbg;

    ram_unit #(
        .ADDR_W (AW),
        .DATA_W (DW)
    ) dut (
        .CLK             (CLK),
        .ARST_L          (ARST_L),
        .SLOW_CLOCK_STRB (SLOW_CLOCK_STRB),
        .mar_in          (mar_in),
        .ram_out         (ram_out),
        .ram_wr          (ram_wr),
        .bus_in          (bus_in),
        .bus_out         (bus_out),
        .bus_oe          (bus_oe),
        .ld_en           (ld_en),
        .ld_valid        (ld_valid),
        .ld_ready        (ld_ready),
        .ld_addr         (ld_addr),
        .ld_data         (ld_data),
        .clr_req         (clr_req),
        .busy            (busy),
        .ld_count        (ld_count),
        .err_conflict    (err_conflict),
        .err_busy        (err_busy),
        .state_dbg       (state_dbg)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Counters and scoreboard
    int            n_checks = 0;
    int            n_fail = 0;
    logic [DW-1:0] exp_q[$];
    logic          mon_take = 1'b0;

    // Reference model
    logic [DW-1:0] m_mem [DEPTH];
    logic [AW-1:0] m_mar = '0;
    int            m_ld_count = 0;
    logic          m_err_conflict = 1'b0;
    logic          m_err_busy = 1'b0;
    logic          m_clearing = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: whenever the driver marks a read sample, compare the bus.
    always @(negedge CLK) begin
        if (mon_take) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL read_sample: got bus_out %0h with no expected entry", bus_out);
            end else begin
                chk("bus_out", 32'(bus_out), 32'(exp_q.pop_front()));
                chk("bus_oe_read", 32'(bus_oe), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // One strobe period: strobe cycle plus three quiet cycles.
    task automatic strobe(input logic mar, input logic wr, input logic out, input logic [DW-1:0] b);
        mar_in = mar;
        ram_wr = wr;
        ram_out = out;
        bus_in = b;
        SLOW_CLOCK_STRB = 1'b1;
        if (m_clearing) begin
            if (mar || wr || out) m_err_busy = 1'b1;
        end else begin
            if (wr && !out) m_mem[m_mar] = b;
            if (wr && out) m_err_conflict = 1'b1;
            if (mar) m_mar = b[AW-1:0];
        end
        tick();
        SLOW_CLOCK_STRB = 1'b0;
        mar_in = 1'b0;
        ram_wr = 1'b0;
        repeat (3) tick();
    endtask

    task automatic set_mar(input logic [AW-1:0] a);
        logic [DW-1:0] b;
        b = {2'($urandom_range(0, 3)), a};
        strobe(1'b1, 1'b0, 1'b0, b);
    endtask

    task automatic cpu_write(input logic [DW-1:0] d);
        strobe(1'b0, 1'b1, 1'b0, d);
    endtask

    task automatic do_read(input logic wr, input logic [DW-1:0] b);
        strobe(1'b0, wr, 1'b1, b);
        exp_q.push_back(m_mem[m_mar]);
        mon_take = 1'b1;
        tick();
        mon_take = 1'b0;
        ram_out = 1'b0;
        tick();
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_en = 1'b1;
        ld_valid = 1'b1;
        ld_addr = a;
        ld_data = d;
        #1;
        chk("ld_ready", 32'(ld_ready), 32'd1);
        m_mem[a] = d;
        if (m_ld_count < DEPTH) m_ld_count++;
        tick();
        ld_valid = 1'b0;
    endtask

    // Full clear; optionally offers a loader word alongside clr_req.
    task automatic do_clear(input logic with_ld);
        int cnt;
        logic done;
        cnt = 0;
        done = 1'b0;
        clr_req = 1'b1;
        if (with_ld) begin
            ld_en = 1'b1;
            ld_valid = 1'b1;
            ld_addr = 8'h55;
            ld_data = 10'h1EE;
            #1;
            chk("ld_ready_vs_clr", 32'(ld_ready), 32'd0);
        end
        tick();
        clr_req = 1'b0;
        ld_valid = 1'b0;
        m_clearing = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge CLK);
            if (!busy) begin
                done = 1'b1;
            end else begin
                cnt++;
                if (i == 10) begin
                    SLOW_CLOCK_STRB = 1'b1;
                    mar_in = 1'b1;
                    bus_in = 10'h0AA;
                    m_err_busy = 1'b1;
                end
                if (i == 11) begin
                    SLOW_CLOCK_STRB = 1'b0;
                    mar_in = 1'b0;
                end
                if (i == 20) ram_out = 1'b1;
                if (i == 21) begin
                    chk("bus_oe_busy", 32'(bus_oe), 32'd0);
                    chk("bus_out_busy", 32'(bus_out), 32'd0);
                    ram_out = 1'b0;
                end
            end
        end
        chk("clear_done", 32'(done), 32'd1);
        chk("busy_cycles", 32'(cnt), 32'(DEPTH));
        m_clearing = 1'b0;
        for (int a = 0; a < DEPTH; a++) m_mem[a] = '0;
        m_ld_count = 0;
        tick();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_bus_out"}, 32'(bus_out), 32'd0);
        chk({tag, "_bus_oe"}, 32'(bus_oe), 32'd0);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_ld_count"}, 32'(ld_count), 32'd0);
        chk({tag, "_err_conflict"}, 32'(err_conflict), 32'd0);
        chk({tag, "_err_busy"}, 32'(err_busy), 32'd0);
        chk({tag, "_state"}, 32'(state_dbg), 32'd0);
    endtask

    // Stimulus
    initial begin
        int op;
        logic [AW-1:0] ra;

        repeat (3) tick();
        chk_reset_outputs("reset");
        ARST_L = 1'b1;
        tick();

        // Initial clear, with a loader word that must lose to clr_req.
        do_clear(1'b1);
        chk("ld_count_after_clear", 32'(ld_count), 32'd0);
        chk("err_busy_sticky", 32'(err_busy), 32'(m_err_busy));

        // Loader write then CPU read-back.
        load(8'h10, 10'h3A5);
        set_mar(8'h10);
        do_read(1'b0, '0);
        chk("ld_count_one", 32'(ld_count), 32'd1);

        // CPU write and read-back.
        set_mar(8'h20);
        cpu_write(10'h155);
        do_read(1'b0, '0);

        // MAR load and write in one strobe: write uses the old MAR.
        strobe(1'b1, 1'b1, 1'b0, 10'h030);
        do_read(1'b0, '0);
        set_mar(8'h20);
        do_read(1'b0, '0);

        // Read/write conflict: read proceeds, write dropped, flag set.
        do_read(1'b1, 10'h2AA);
        chk("err_conflict", 32'(err_conflict), 32'd1);

        // CPU write and loader word in the same cycle: CPU wins.
        set_mar(8'h41);
        ld_en = 1'b1;
        ld_valid = 1'b1;
        ld_addr = 8'h40;
        ld_data = 10'h111;
        SLOW_CLOCK_STRB = 1'b1;
        ram_wr = 1'b1;
        bus_in = 10'h222;
        #1;
        chk("ld_ready_vs_cpu", 32'(ld_ready), 32'd0);
        m_mem[m_mar] = 10'h222;
        tick();
        SLOW_CLOCK_STRB = 1'b0;
        ram_wr = 1'b0;
        ld_valid = 1'b0;
        repeat (3) tick();
        do_read(1'b0, '0);
        set_mar(8'h40);
        do_read(1'b0, '0);
        chk("ld_count_cpu_win", 32'(ld_count), 32'(m_ld_count));

        // Random mix of CPU and loader operations.
        for (int n = 0; n < 80; n++) begin
            op = $urandom_range(0, 4);
            ra = AW'($urandom_range(0, DEPTH - 1));
            case (op)
                0: load(ra, DW'($urandom_range(0, 1023)));
                1: set_mar(ra);
                2: cpu_write(DW'($urandom_range(0, 1023)));
                3: do_read(1'b0, '0);
                default: do_read(1'b1, DW'($urandom_range(0, 1023)));
            endcase
        end
        chk("ld_count_random", 32'(ld_count), 32'(m_ld_count));

        // Second clear: a strobe during the clear must not move MAR.
        set_mar(8'h33);
        do_clear(1'b0);
        chk("ld_count_clear2", 32'(ld_count), 32'd0);
        cpu_write(10'h2C3);
        set_mar(8'hAA);
        do_read(1'b0, '0);
        set_mar(8'h33);
        do_read(1'b0, '0);
        for (int k = 0; k < 8; k++) begin
            set_mar(AW'($urandom_range(0, DEPTH - 1)));
            do_read(1'b0, '0);
        end

        // Fill all of memory through the loader; counter saturates.
        for (int a = 0; a < DEPTH + 4; a++) begin
            load(AW'(a), DW'($urandom_range(0, 1023)));
        end
        chk("ld_count_sat", 32'(ld_count), 32'(DEPTH));

        // Reset 50 cycles into a clear: only the first 49 words are zeroed.
        ld_en = 1'b0;
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        repeat (50) @(negedge CLK);
        ARST_L = 1'b0;
        #1;
        chk_reset_outputs("midclr");
        repeat (3) tick();
        ARST_L = 1'b1;
        tick();
        for (int a = 0; a < 49; a++) m_mem[a] = '0;
        m_mar = '0;
        m_ld_count = 0;
        m_err_conflict = 1'b0;
        m_err_busy = 1'b0;
        chk("busy_after_abort", 32'(busy), 32'd0);
        do_read(1'b0, '0);
        for (int a = 0; a < DEPTH; a++) begin
            set_mar(AW'(a));
            do_read(1'b0, '0);
        end

        chk("err_conflict_final", 32'(err_conflict), 32'(m_err_conflict));
        chk("err_busy_final", 32'(err_busy), 32'(m_err_busy));
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ram_unit.md
# ram_unit

Bus-side memory responder for the SAP CPU. It executes the RAM strobes issued by the CPU control logic: memory-address-register load, read-out onto the data bus, and write from the bus, all qualified by the slow-clock strobe. It also provides a halted-mode program loader port and a whole-memory clear sequencer. It sits between the shared data bus and the CPU control block and is the only owner of program/data storage.

## Interface
- ADDR_W, 8, address width; memory depth DEPTH = 2**ADDR_W
- DATA_W, 10, bus/word width (opcode word width)
- CLK  in  1  fast system clock
- ARST_L  in  1  reset, asynchronous, active-low
- SLOW_CLOCK_STRB  in  1  one-CLK-wide step strobe; CPU strobes are sampled only when high
- mar_in  in  1  latch bus_in[ADDR_W-1:0] into MAR at the strobe
- ram_out  in  1  drive mem[MAR] onto bus_out
- ram_wr  in  1  write bus_in into mem[MAR] at the strobe
- bus_in  in  DATA_W  shared data bus value
- bus_out  out  DATA_W  read data; 0 when bus_oe=0
- bus_oe  out  1  bus drive enable (= ram_out, suppressed while busy)
- ld_en  in  1  loader permitted (CPU halted)
- ld_valid  in  1  loader word valid
- ld_ready  out  1  loader word accepted this CLK
- ld_addr  in  ADDR_W  loader address
- ld_data  in  DATA_W  loader data
- clr_req  in  1  start whole-memory clear (pulse)
- busy  out  1  clear in progress
- ld_count  out  ADDR_W+1  words accepted by loader since reset/clear, saturating
- err_conflict  out  1  sticky: ram_out and ram_wr in same strobe
- err_busy  out  1  sticky: CPU strobe arrived while busy

## Operation
- FSM states IDLE, CLEAR. Reset → IDLE.
- IDLE, clr_req=1 → CLEAR, clear counter=0. CLEAR writes 0 to mem[counter] each CLK, counter+1; after writing DEPTH-1 → IDLE. Duration exactly DEPTH CLKs, busy=1 throughout. clr_req during CLEAR ignored. Completing clear resets ld_count to 0.
- Loader: ld_ready = (state==IDLE && ld_en && !clr_req). Transfer when ld_valid && ld_ready: mem[ld_addr] <= ld_data at that edge, ld_count+1 (saturates at DEPTH). clr_req has priority over a simultaneous loader word.
- CPU strobes (SLOW_CLOCK_STRB=1), state IDLE:
  - mar_in: MAR <= bus_in[ADDR_W-1:0].
  - ram_wr && !ram_out: mem[MAR] <= bus_in using MAR value before this edge (mar_in in same strobe updates MAR after).
  - ram_wr && ram_out: write suppressed, read proceeds, err_conflict <= 1.
  - CPU write and loader transfer on same CLK: CPU write wins, ld_ready forced 0 that CLK.
- Any of mar_in/ram_wr/ram_out at a strobe while state==CLEAR: strobe dropped (MAR unchanged, no write), err_busy <= 1.
- Read path: rd_data <= mem[MAR] every CLK (synchronous RAM). bus_out = bus_oe ? rd_data : 0; bus_oe = ram_out && !busy.
- Error flags cleared only by reset.
- Memory contents are not reset.

## Timing
- Reset values: MAR=0, rd_data=0, bus_out=0, bus_oe=0, ld_ready=0, busy=0, ld_count=0, err_conflict=0, err_busy=0, state IDLE.
- MAR update at strobe edge T; rd_data reflects new address at T+1 CLK. bus_out valid for new MAR from T+1; the system requires ≥4 CLK per strobe period, so data is stable before the next strobe.
- Write at strobe edge T; read of same address shows new data at T+1.
- bus_oe is combinational from ram_out; no latency.
- Loader: one word per CLK maximum; ld_ready combinational from state/ld_en/clr_req/CPU write.
- Clear: busy rises the CLK after clr_req is sampled and falls after DEPTH CLKs.
- Reset mid-clear: abort immediately, memory partially cleared; no resume.

## Structure
- Shared package: ADDR_W/DATA_W defaults, FSM state encoding (IDLE=0, CLEAR=1).
- One sub-module: ram_array (DEPTH×DATA_W, one synchronous write port, one synchronous read port). Write-port mux (clear / CPU / loader) and FSM live in ram_unit.

## Test plan
- Loader writes 0x3A5 to addr 0x10 with ld_en=1; strobe mar_in with bus_in=0x010, then ram_out → bus_out=0x3A5, bus_oe=1 from next CLK; ld_count=1.
- Strobe mar_in with bus_in=0x020; next strobe ram_wr with bus_in=0x155 → mem[0x20]=0x155; read back gives 0x155.
- Same strobe mar_in (bus_in=0x030) + ram_wr with MAR=0x20 → write lands at 0x20, MAR becomes 0x30.
- ram_out and ram_wr in same strobe → no write, bus_out=mem[MAR], err_conflict=1 until reset.
- clr_req pulse → busy high exactly 256 CLKs, every address reads 0, ld_count=0; a mar_in strobe during clear leaves MAR unchanged and sets err_busy.
- Assert ARST_L low 50 CLKs into a clear → all outputs at reset values, state IDLE, addresses ≥50 retain prior contents.
